// File: rtl/iob_axi_master_bridge_pkg.sv
// Shared AXI constants and bridge FSM encoding.
// Imported by the bridge and its testbench.
package iob_axi_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
   localparam logic [7:0] AXI_LEN_SINGLE    = 8'd0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4
   } state_t;

   // EXOKAY is never expected for plain accesses, so it counts as an error.
   function automatic logic resp_err(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/iob_axi_master_bridge_if.sv
// Native request bus plus AXI4 master channels of the bridge.
// master: bridge view (native slave, AXI master); slave: CPU + memory view.
interface iob_axi_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              error;

   logic              m_axi_awvalid;
   logic              m_axi_awready;
   logic [ADDR_W-1:0] m_axi_awaddr;
   logic [3:0]        m_axi_awid;
   logic [7:0]        m_axi_awlen;
   logic [2:0]        m_axi_awsize;
   logic [1:0]        m_axi_awburst;
   logic              m_axi_awlock;
   logic [3:0]        m_axi_awcache;
   logic [2:0]        m_axi_awprot;

   logic              m_axi_wvalid;
   logic              m_axi_wready;
   logic [DATA_W-1:0] m_axi_wdata;
   logic [3:0]        m_axi_wstrb;
   logic              m_axi_wlast;

   logic              m_axi_bvalid;
   logic              m_axi_bready;
   logic [1:0]        m_axi_bresp;
   logic [3:0]        m_axi_bid;

   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [3:0]        m_axi_arid;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_arlock;
   logic [3:0]        m_axi_arcache;
   logic [2:0]        m_axi_arprot;

   logic              m_axi_rvalid;
   logic              m_axi_rready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic [3:0]        m_axi_rid;
   logic              m_axi_rlast;

   modport master (
      input  valid, addr, wdata, wstrb,
      output rdata, ready, error,
      output m_axi_awvalid, m_axi_awaddr, m_axi_awid,
      output m_axi_awlen, m_axi_awsize, m_axi_awburst,
      output m_axi_awlock, m_axi_awcache, m_axi_awprot,
      input  m_axi_awready,
      output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      output m_axi_wlast,
      input  m_axi_wready,
      input  m_axi_bvalid, m_axi_bresp, m_axi_bid,
      output m_axi_bready,
      output m_axi_arvalid, m_axi_araddr, m_axi_arid,
      output m_axi_arlen, m_axi_arsize, m_axi_arburst,
      output m_axi_arlock, m_axi_arcache, m_axi_arprot,
      input  m_axi_arready,
      input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      input  m_axi_rid, m_axi_rlast,
      output m_axi_rready
   );

   modport slave (
      output valid, addr, wdata, wstrb,
      input  rdata, ready, error,
      input  m_axi_awvalid, m_axi_awaddr, m_axi_awid,
      input  m_axi_awlen, m_axi_awsize, m_axi_awburst,
      input  m_axi_awlock, m_axi_awcache, m_axi_awprot,
      output m_axi_awready,
      input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      input  m_axi_wlast,
      output m_axi_wready,
      output m_axi_bvalid, m_axi_bresp, m_axi_bid,
      input  m_axi_bready,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arid,
      input  m_axi_arlen, m_axi_arsize, m_axi_arburst,
      input  m_axi_arlock, m_axi_arcache, m_axi_arprot,
      output m_axi_arready,
      output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      output m_axi_rid, m_axi_rlast,
      input  m_axi_rready
   );

endinterface

// File: rtl/iob_axi_master_bridge.sv
// Single-beat native request to AXI4 master bridge, one access in flight.
// Ports: clk, rst_n (async, active-low), bus (native + AXI, master view).
module iob_axi_master_bridge #(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input logic                     clk,
   input logic                     rst_n,
   iob_axi_master_bridge_if.master bus
);

   import iob_axi_pkg::*;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic [DATA_W-1:0] rdata_q, rdata_n;
   logic [3:0]        wstrb_q, wstrb_n;
   logic              awvalid_q, awvalid_n;
   logic              wvalid_q, wvalid_n;
   logic              bready_q, bready_n;
   logic              arvalid_q, arvalid_n;
   logic              rready_q, rready_n;
   logic              ready_q, ready_n;
   logic              error_q, error_n;
   logic              aw_done_q, aw_done_n;
   logic              w_done_q, w_done_n;

   logic              aw_hs, w_hs, ar_hs;
   logic              aw_ok, w_ok;
   logic              unused_ok;

   assign aw_hs = awvalid_q & bus.m_axi_awready;
   assign w_hs  = wvalid_q & bus.m_axi_wready;
   assign ar_hs = arvalid_q & bus.m_axi_arready;
   assign aw_ok = aw_done_q | aw_hs;
   assign w_ok  = w_done_q | w_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state     <= state_n;
         addr_q    <= addr_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         rdata_q   <= rdata_n;
         awvalid_q <= awvalid_n;
         wvalid_q  <= wvalid_n;
         bready_q  <= bready_n;
         arvalid_q <= arvalid_n;
         rready_q  <= rready_n;
         ready_q   <= ready_n;
         error_q   <= error_n;
         aw_done_q <= aw_done_n;
         w_done_q  <= w_done_n;
      end
   end

   always_comb begin
      state_n   = state;
      addr_n    = addr_q;
      wdata_n   = wdata_q;
      wstrb_n   = wstrb_q;
      rdata_n   = rdata_q;
      awvalid_n = awvalid_q;
      wvalid_n  = wvalid_q;
      bready_n  = bready_q;
      arvalid_n = arvalid_q;
      rready_n  = rready_q;
      ready_n   = 1'b0;
      error_n   = error_q;
      aw_done_n = aw_done_q;
      w_done_n  = w_done_q;

      unique case (state)
         ST_IDLE: begin
            // The requester still holds valid in the ready cycle;
            // skipping it there avoids replaying the finished access.
            if (bus.valid && !ready_q) begin
               addr_n  = bus.addr;
               wdata_n = bus.wdata;
               wstrb_n = bus.wstrb;
               if (bus.wstrb != 4'd0) begin
                  state_n   = ST_WRITE;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  aw_done_n = 1'b0;
                  w_done_n  = 1'b0;
               end else begin
                  state_n   = ST_RADDR;
                  arvalid_n = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            aw_done_n = aw_ok;
            w_done_n  = w_ok;
            if (aw_hs) awvalid_n = 1'b0;
            if (w_hs)  wvalid_n  = 1'b0;
            if (aw_ok && w_ok) begin
               state_n   = ST_WRESP;
               bready_n  = 1'b1;
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
            end
         end
         ST_WRESP: begin
            if (bus.m_axi_bvalid && bready_q) begin
               state_n  = ST_IDLE;
               bready_n = 1'b0;
               ready_n  = 1'b1;
               error_n  = resp_err(bus.m_axi_bresp);
            end
         end
         ST_RADDR: begin
            if (ar_hs) begin
               state_n   = ST_RDATA;
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
            end
         end
         ST_RDATA: begin
            if (bus.m_axi_rvalid && rready_q) begin
               state_n  = ST_IDLE;
               rready_n = 1'b0;
               ready_n  = 1'b1;
               rdata_n  = bus.m_axi_rdata;
               error_n  = resp_err(bus.m_axi_rresp);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.error = error_q;

   assign bus.m_axi_awvalid = awvalid_q;
   assign bus.m_axi_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.m_axi_awid    = AXI_ID;
   assign bus.m_axi_awlen   = AXI_LEN_SINGLE;
   assign bus.m_axi_awsize  = AXI_SIZE_4B;
   assign bus.m_axi_awburst = AXI_BURST_INCR;
   assign bus.m_axi_awlock  = 1'b0;
   assign bus.m_axi_awcache = AXI_CACHE_DEFAULT;
   assign bus.m_axi_awprot  = AXI_PROT_DEFAULT;

   assign bus.m_axi_wvalid = wvalid_q;
   assign bus.m_axi_wdata  = wdata_q;
   assign bus.m_axi_wstrb  = wstrb_q;
   assign bus.m_axi_wlast  = wvalid_q;

   assign bus.m_axi_bready = bready_q;

   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.m_axi_arid    = AXI_ID;
   assign bus.m_axi_arlen   = AXI_LEN_SINGLE;
   assign bus.m_axi_arsize  = AXI_SIZE_4B;
   assign bus.m_axi_arburst = AXI_BURST_INCR;
   assign bus.m_axi_arlock  = 1'b0;
   assign bus.m_axi_arcache = AXI_CACHE_DEFAULT;
   assign bus.m_axi_arprot  = AXI_PROT_DEFAULT;

   assign bus.m_axi_rready = rready_q;

   // Single-beat, single-ID traffic: response IDs and rlast carry no info.
   assign unused_ok = ^{addr_q[1:0], bus.m_axi_bid,
                        bus.m_axi_rid, bus.m_axi_rlast};

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Bench for iob_axi_master_bridge: AXI RAM responder plus scoreboard.
// Native requests push expectations; ready pulses pop and compare.
module tb_iob_axi_master_bridge;

   import iob_axi_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   iob_axi_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   iob_axi_master_bridge #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .AXI_ID(4'd0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   int n_vec = 0;
   int n_bad = 0;

   exp_t        sb[$];
   logic [31:0] exp_mem[int unsigned];
   logic [31:0] last_rd = '0;

   int          aw_delay = 0;
   int          w_delay = 0;
   int          r_delay = 0;
   logic [1:0]  bresp_cfg = AXI_RESP_OKAY;
   logic [1:0]  rresp_cfg = AXI_RESP_OKAY;

   int          aw_cnt = 0;
   int          w_cnt = 0;
   int          b_cnt = 0;
   int          ar_cnt = 0;
   int          r_cnt = 0;
   int          w_first_cnt = 0;
   logic [31:0] last_awaddr = '0;
   logic [31:0] smem[int unsigned];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // AXI RAM responder; all decisions are taken on the falling edge.
   initial begin : slave
      int          aw_w, w_w, r_w;
      logic        got_aw, got_w, got_ar, pb, pr;
      logic [31:0] sa, sd, ra;
      logic [3:0]  ss;
      int unsigned k;
      aw_w = 0; w_w = 0; r_w = 0;
      got_aw = 0; got_w = 0; got_ar = 0; pb = 0; pr = 0;
      sa = '0; sd = '0; ra = '0; ss = '0;
      bus.m_axi_awready = 0; bus.m_axi_wready = 0;
      bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0; bus.m_axi_bid = 0;
      bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
      bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
      bus.m_axi_rid = 0; bus.m_axi_rlast = 1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            aw_w = 0; w_w = 0; r_w = 0;
            got_aw = 0; got_w = 0; got_ar = 0; pb = 0; pr = 0;
            bus.m_axi_awready = 0; bus.m_axi_wready = 0;
            bus.m_axi_bvalid = 0; bus.m_axi_arready = 0;
            bus.m_axi_rvalid = 0;
         end else begin
            if (bus.m_axi_wready && !bus.m_axi_awready && !got_aw)
               w_first_cnt++;
            if (bus.m_axi_awready) begin got_aw = 1; aw_cnt++; end
            if (bus.m_axi_wready)  begin got_w = 1;  w_cnt++;  end
            if (bus.m_axi_arready) begin got_ar = 1; ar_cnt++; end
            if (bus.m_axi_bvalid && pb) begin
               b_cnt++; bus.m_axi_bvalid = 0;
            end
            if (bus.m_axi_rvalid && pr) begin
               r_cnt++; bus.m_axi_rvalid = 0;
            end

            bus.m_axi_awready = 0;
            if (bus.m_axi_awvalid && !got_aw) begin
               if (aw_w >= aw_delay) begin
                  bus.m_axi_awready = 1; aw_w = 0;
                  sa = bus.m_axi_awaddr;
                  chk("awlen", bus.m_axi_awlen, 0);
                  chk("awsize", bus.m_axi_awsize, 2);
                  chk("awburst", bus.m_axi_awburst, 1);
                  chk("awcache", bus.m_axi_awcache, 3);
                  chk("awlockprotid", {bus.m_axi_awlock,
                      bus.m_axi_awprot, bus.m_axi_awid}, 0);
               end else aw_w++;
            end

            bus.m_axi_wready = 0;
            if (bus.m_axi_wvalid && !got_w) begin
               if (w_w >= w_delay) begin
                  bus.m_axi_wready = 1; w_w = 0;
                  sd = bus.m_axi_wdata; ss = bus.m_axi_wstrb;
                  chk("wlast", bus.m_axi_wlast, 1);
               end else w_w++;
            end

            bus.m_axi_arready = 0;
            if (bus.m_axi_arvalid && !got_ar) begin
               bus.m_axi_arready = 1;
               ra = bus.m_axi_araddr;
               chk("arlen", bus.m_axi_arlen, 0);
               chk("arsize", bus.m_axi_arsize, 2);
            end

            if (got_aw && got_w && !bus.m_axi_bvalid) begin
               k = sa >> 2;
               smem[k] = merge(smem.exists(k) ? smem[k] : '0, sd, ss);
               last_awaddr = sa;
               bus.m_axi_bvalid = 1; bus.m_axi_bresp = bresp_cfg;
               got_aw = 0; got_w = 0;
            end

            if (got_ar && !bus.m_axi_rvalid) begin
               if (r_w >= r_delay) begin
                  k = ra >> 2;
                  bus.m_axi_rdata = smem.exists(k) ? smem[k] : '0;
                  bus.m_axi_rresp = rresp_cfg;
                  bus.m_axi_rvalid = 1;
                  got_ar = 0; r_w = 0;
               end else r_w++;
            end
            pb = bus.m_axi_bready;
            pr = bus.m_axi_rready;
         end
      end
   end

   task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic e_err);
      exp_t        e;
      int unsigned k;
      k = a >> 2;
      if (s != 4'd0)
         exp_mem[k] = merge(exp_mem.exists(k) ? exp_mem[k] : '0, d, s);
      else
         last_rd = exp_mem.exists(k) ? exp_mem[k] : '0;
      e.rdata = last_rd;
      e.err = e_err;
      sb.push_back(e);
      bus.valid = 1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
   endtask

   task automatic wait_done(output int lat);
      exp_t e;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.ready && lat < 100);
      e = sb.pop_front();
      if (!bus.ready) chk("ready_timeout", 0, 1);
      else begin
         chk("rdata", bus.rdata, e.rdata);
         chk("error", bus.error, e.err);
      end
      bus.valid = 0; bus.wstrb = 0;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic e_err,
                         output int lat);
      start_req(a, d, s, e_err);
      wait_done(lat);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time %0t, bench did not finish", $time);
      $fatal(1);
   end

   initial begin : main
      int lat, a0, w0, b0, ar0, pulses;
      bus.valid = 0; bus.addr = 0; bus.wdata = 0; bus.wstrb = 0;

      rst_n = 0;
      repeat (4) begin
         @(negedge clk);
         bus.valid = 1'($urandom);
         bus.addr = $urandom;
         bus.wdata = $urandom;
         bus.wstrb = 4'($urandom);
      end
      @(negedge clk);
      chk("rst_axi_valid", {bus.m_axi_awvalid, bus.m_axi_wvalid,
          bus.m_axi_arvalid}, 0);
      chk("rst_axi_ready", {bus.m_axi_bready, bus.m_axi_rready}, 0);
      chk("rst_ready", bus.ready, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_error", bus.error, 0);
      bus.valid = 0; bus.wstrb = 0;
      rst_n = 1;
      repeat (2) @(negedge clk);

      do_req(32'h100, 32'hDEADBEEF, 4'hF, 0, lat);
      chk("wr_latency", lat, 3);
      chk("aw_cnt", aw_cnt, 1);
      chk("w_cnt", w_cnt, 1);
      @(negedge clk);
      do_req(32'h100, 32'h0, 4'h0, 0, lat);
      chk("rd_latency", lat, 3);

      do_req(32'h200, 32'h11223344, 4'hF, 0, lat);
      do_req(32'h203, 32'hAA000000, 4'h8, 0, lat);
      chk("awaddr_align", last_awaddr, 32'h200);
      do_req(32'h200, 32'h0, 4'h0, 0, lat);

      aw_delay = 5; w_delay = 0;
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      do_req(32'h104, 32'hCAFEF00D, 4'hF, 0, lat);
      chk("skew_w_first", w_first_cnt, 1);
      chk("skew_aw", aw_cnt - a0, 1);
      chk("skew_w", w_cnt - w0, 1);
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.ready) pulses++;
      end
      chk("skew_b", b_cnt - b0, 1);
      chk("skew_extra_ready", pulses, 0);
      aw_delay = 0;
      do_req(32'h104, 32'h0, 4'h0, 0, lat);

      rresp_cfg = AXI_RESP_SLVERR;
      do_req(32'h100, 32'h0, 4'h0, 1, lat);
      rresp_cfg = AXI_RESP_OKAY;
      do_req(32'h400, 32'h01020304, 4'hF, 0, lat);
      bresp_cfg = AXI_RESP_DECERR;
      do_req(32'h404, 32'h0BADF00D, 4'h3, 1, lat);
      bresp_cfg = AXI_RESP_OKAY;

      r_delay = 5;
      a0 = aw_cnt; ar0 = ar_cnt;
      @(negedge clk);
      start_req(32'h200, 32'h0, 4'h0, 0);
      lat = 0;
      while (!bus.m_axi_rready && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("rdata_state_seen", bus.m_axi_rready, 1);
      bus.addr = 32'h300; bus.wdata = 32'h55555555; bus.wstrb = 4'hF;
      wait_done(lat);
      repeat (5) @(negedge clk);
      chk("ignore_aw", aw_cnt - a0, 0);
      chk("ignore_ar", ar_cnt - ar0, 1);
      r_delay = 0;

      aw_delay = 20; w_delay = 20;
      bus.valid = 1; bus.addr = 32'h100;
      bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
      repeat (3) @(negedge clk);
      chk("busy_awvalid", bus.m_axi_awvalid, 1);
      chk("busy_wvalid", bus.m_axi_wvalid, 1);
      #2 rst_n = 0;
      #1;
      chk("abort_awvalid", bus.m_axi_awvalid, 0);
      chk("abort_wvalid", bus.m_axi_wvalid, 0);
      chk("abort_rdata", bus.rdata, 0);
      bus.valid = 0; bus.wstrb = 0;
      last_rd = '0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      aw_delay = 0; w_delay = 0;
      @(negedge clk);
      do_req(32'h100, 32'h0, 4'h0, 0, lat);
      chk("post_rst_latency", lat, 3);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/iob_axi_master_bridge.md
Name: iob_axi_master_bridge

Overview:
- Converts the single-beat native memory request interface (valid/addr/wdata/wstrb → rdata/ready) into AXI4 master transactions.
- Sits directly upstream of the axi_ram / ddr3_axi slave: CPU-side requests enter here, and AXI AW/W/B/AR/R leave here toward the DDR3 controller.
- At most one transaction is in flight at a time.
- A non-zero wstrb selects a write; wstrb == 0 selects a read.

Parameters:
- ADDR_W, 32, native and AXI address width
- DATA_W, 32, data width; only 32 is supported (AXI size fixed to 4 bytes)
- AXI_ID, 0, constant 4-bit ID driven on awid/arid

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- valid  in  1  native request strobe
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- wstrb  in  4  byte enables; 0 means read
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- error  out  1  qualified by ready; set when bresp/rresp != OKAY
- m_axi_awvalid/awready  out/in  1  write-address handshake
- m_axi_awaddr  out  ADDR_W  write address
- m_axi_awid  out  4  write ID
- m_axi_awlen  out  8  burst length
- m_axi_awsize  out  3  beat size
- m_axi_awburst  out  2  burst type
- m_axi_awlock  out  1  lock
- m_axi_awcache  out  4  cache attributes
- m_axi_awprot  out  3  protection
- m_axi_wvalid/wready  out/in  1  write-data handshake
- m_axi_wdata  out  DATA_W  write data
- m_axi_wstrb  out  4  write strobes
- m_axi_wlast  out  1  last beat
- m_axi_bvalid/bready  in/out  1  write-response handshake
- m_axi_bresp  in  2  write response
- m_axi_bid  in  4  write response ID
- m_axi_ar*  out/in  as AW, minus W-side fields  read address channel
- m_axi_rvalid/rready  in/out  1  read-data handshake
- m_axi_rdata  in  DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rid  in  4  read ID
- m_axi_rlast  in  1  last beat

Behaviour:
- Constant AXI fields:
  - len = 0, size = 3'b010, burst = INCR (2'b01)
  - lock = 0, cache = 4'b0011, prot = 3'b000
  - wlast = 1 whenever wvalid = 1
  - a/w addr is driven as {addr[ADDR_W-1:2], 2'b00}
- Reset (rst_n = 0, asynchronous):
  - state = IDLE
  - all valid/ready outputs = 0; rdata = 0; error = 0; captured registers = 0
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE:
  - On valid=1, capture addr, wdata and wstrb.
  - If wstrb != 0, go to WRITE and assert awvalid and wvalid the next cycle.
  - Otherwise go to RADDR and assert arvalid the next cycle.
- WRITE:
  - awvalid and wvalid are held independently until their own handshakes complete; sticky aw_done/w_done flags track this.
  - Both handshakes may occur in the same cycle.
  - Once both are done, deassert awvalid/wvalid, assert bready, and go to WRESP.
  - A W handshake that precedes AW is legal.
- WRESP:
  - On bvalid & bready, deassert bready, pulse ready for one cycle, set error = (bresp != 2'b00), return to IDLE.
  - rdata is not updated.
- RADDR:
  - arvalid is held until arready.
  - Then assert rready and go to RDATA.
- RDATA:
  - On rvalid & rready, register rdata and error = (rresp != 2'b00), pulse ready, deassert rready, return to IDLE.
  - rlast is ignored (len = 0); an rid mismatch is ignored.
- Latency with an always-ready slave:
  - Write: valid at cycle 0 → AW/W handshake at cycle 1 → bvalid at cycle 2 earliest → ready at cycle 3.
  - Read: same timing, with the R handshake replacing B.
- Native handshake rules:
  - valid is sampled only in IDLE; valid during a busy state is ignored.
  - The requester holds its request stable until ready.
  - A new request may be accepted in the cycle after ready.
- rdata/error persist until the next completion.
- All AXI valid signals are register outputs. No combinational path from any *ready input to any *valid output.
- Reset mid-transaction aborts the transaction and drops to IDLE; the slave is required to share the same reset.

Decomposition:
- Shared package (iob_axi_pkg): AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_BURST_INCR, AXI_SIZE_4B, AXI_CACHE_DEFAULT, and the FSM state encoding (3-bit).
- No sub-module: a single FSM plus capture registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all AXI valid/ready outputs = 0, ready = 0, rdata = 0; release → IDLE.
- Write then read through axi_ram: write addr 0x100, wdata 0xDEADBEEF, wstrb 4'hF → one AW (len 0, size 2) and one W (wlast 1), ready pulse, error 0. Then read 0x100 with wstrb 0 → rdata 0xDEADBEEF.
- Byte strobe: write 0x11223344 to 0x200, then write 0xAA000000 with wstrb 4'h8 → read returns 0xAA223344; awaddr 0x203 is driven as 0x200.
- Channel skew: slave asserts wready 5 cycles before awready → W completes first, awvalid holds until accepted, exactly one B consumed, one ready pulse.
- Error response: slave returns rresp=2'b10 → ready=1 with error=1; the following OKAY write returns error=0.
- Abort/ignore: assert valid while in RDATA → request ignored. Pull rst_n low mid-WRITE → awvalid/wvalid drop combinationally with reset; after release, a fresh read of 0x100 completes correctly.
